// File: rtl/pipelined_adder_risc.sv
// Pipelined two's-complement adder/subtractor, STAGES carry segments, valid/ready with backpressure.
// Define ADDER_SAT_EN to build signed saturation driven by in_sat.
module pipelined_adder_risc #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int unsigned SEG = WIDTH / STAGES;

  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [STAGES-1:0][WIDTH-1:0] a_src, b_src, s_src;
  logic [STAGES-1:0]            c_q, c_d, v_q, v_d, c_src, v_src;
  logic [WIDTH-1:0]             sum_q, sum_d, fin_sum;
  logic                         ovf_q, ovf_d, zero_q, zero_d;
  logic [SEG:0]                 seg_res;
  logic                         adv, en, a_msb;

`ifdef ADDER_SAT_EN
  logic [STAGES-1:0] sat_q, sat_d, sat_src;
  logic unused_sat_tail;
  assign unused_sat_tail = sat_q[STAGES-1];
`else
  logic unused_sat;
  assign unused_sat = in_sat;
`endif

  // Last-stage operand/partial copies are superseded by the output registers.
  logic unused_tail;
  assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], s_q[STAGES-1]};

  assign adv      = !v_q[STAGES-1] || out_ready;
  assign en       = adv || flush;
  assign in_ready = adv;

  always_comb begin
    a_src    = '0;
    b_src    = '0;
    s_src    = '0;
    c_src    = '0;
    v_src    = '0;
    a_src[0] = in_a;
    b_src[0] = in_sub ? ~in_b : in_b;
    c_src[0] = in_sub;
    v_src[0] = in_valid;
`ifdef ADDER_SAT_EN
    sat_src    = '0;
    sat_src[0] = in_sat;
`endif
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
      v_src[k] = v_q[k-1];
`ifdef ADDER_SAT_EN
      sat_src[k] = sat_q[k-1];
`endif
    end
  end

  always_comb begin
    a_d     = '0;
    b_d     = '0;
    s_d     = '0;
    c_d     = '0;
    v_d     = '0;
    seg_res = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg_res = {1'b0, a_src[k][k*SEG +: SEG]} + {1'b0, b_src[k][k*SEG +: SEG]}
              + {{SEG{1'b0}}, c_src[k]};
      a_d[k]                = a_src[k];
      b_d[k]                = b_src[k];
      s_d[k]                = s_src[k];
      s_d[k][k*SEG +: SEG]  = seg_res[SEG-1:0];
      c_d[k]                = seg_res[SEG];
      v_d[k]                = v_src[k] && !flush;
    end
`ifdef ADDER_SAT_EN
    sat_d = sat_src;
`endif
    fin_sum = s_d[STAGES-1];
    a_msb   = a_d[STAGES-1][WIDTH-1];
    ovf_d   = (a_msb == b_d[STAGES-1][WIDTH-1]) && (fin_sum[WIDTH-1] != a_msb);
`ifdef ADDER_SAT_EN
    // Operand sign picks the clamp direction: positive operands clamp to max.
    if (sat_d[STAGES-1] && ovf_d) begin
      fin_sum = {a_msb, {(WIDTH-1){~a_msb}}};
    end
`endif
    sum_d  = fin_sum;
    zero_d = ~|fin_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      c_q    <= '0;
      v_q    <= '0;
      sum_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
`ifdef ADDER_SAT_EN
      sat_q  <= '0;
`endif
    end else if (en) begin
      a_q    <= a_d;
      b_q    <= b_d;
      s_q    <= s_d;
      c_q    <= c_d;
      v_q    <= v_d;
      sum_q  <= sum_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
`ifdef ADDER_SAT_EN
      sat_q  <= sat_d;
`endif
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_sum   = sum_q;
  assign out_carry = c_q[STAGES-1];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_adder_risc.sv
// Scoreboard bench for pipelined_adder_risc: 32/2 main instance plus 64/4 and 32/1 spot checks.
module tb_pipelined_adder_risc;
  logic        clk, rst_n, flush;
  logic        in_valid, in_ready, in_sub, in_sat;
  logic [31:0] in_a, in_b, out_sum;
  logic        out_valid, out_ready, out_carry, out_ovf, out_zero;

  logic        v64, r64, ov64, c64, o64, z64;
  logic [63:0] a64, b64, s64;
  logic        v1, r1, ov1, c1, o1, z1;
  logic [31:0] a1, b1, s1;

  typedef struct {
    string       name;
    logic [31:0] sum;
    logic        c, v, z;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef ADDER_SAT_EN
  localparam logic [31:0] SatAddExp = 32'h7FFF_FFFF;
  localparam logic [31:0] SatSubExp = 32'h8000_0000;
`else
  localparam logic [31:0] SatAddExp = 32'h8000_0000;
  localparam logic [31:0] SatSubExp = 32'h7FFF_FFFF;
`endif

  pipelined_adder_risc #(.WIDTH(32), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_sat(in_sat), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_zero(out_zero)
  );

  pipelined_adder_risc #(.WIDTH(64), .STAGES(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(v64), .in_ready(r64),
    .in_a(a64), .in_b(b64), .in_sub(1'b0), .in_sat(1'b0), .out_valid(ov64),
    .out_ready(1'b1), .out_sum(s64), .out_carry(c64), .out_ovf(o64), .out_zero(z64)
  );

  pipelined_adder_risc #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(v1), .in_ready(r1),
    .in_a(a1), .in_b(b1), .in_sub(1'b0), .in_sat(1'b0), .out_valid(ov1),
    .out_ready(1'b1), .out_sum(s1), .out_carry(c1), .out_ovf(o1), .out_zero(z1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", out_valid, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_sum"}, out_sum, e.sum);
        chk({e.name, "_flags"}, {out_carry, out_ovf, out_zero}, {e.c, e.v, e.z});
      end
    end
  end

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic sat, input logic [31:0] es,
                       input logic ec, input logic ev, input logic ez);
    int  n    = 0;
    bit  done = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_sat   = sat;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        exp_q.push_back('{nm, es, ec, ev, ez});
        done = 1;
      end else if (++n > 50) begin
        chk({nm, "_accept_timeout"}, in_ready, 1'b1);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, input int lat);
    int n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, n, lat);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    int          n;
    logic [31:0] hold;
    clk = 0; rst_n = 0; flush = 0; in_valid = 0; in_sub = 0; in_sat = 0;
    in_a = '0; in_b = '0; out_ready = 1;
    v64 = 0; a64 = '0; b64 = '0; v1 = 0; a1 = '0; b1 = '0;
    #12;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_sum", out_sum, 32'h0);
    chk("reset_flags", {out_carry, out_ovf, out_zero}, 3'b000);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1'b1);

    // Directed arithmetic vectors.
    issue("add_seg_carry", 32'h0000_FFFF, 32'h1, 0, 0, 32'h0001_0000, 0, 0, 0);
    wait_out("latency_add", 2);
    issue("sub_5_5", 32'h5, 32'h5, 1, 0, 32'h0, 1, 0, 1);
    issue("sub_0_1", 32'h0, 32'h1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    issue("add_ovf_wrap", 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1, 0);
    issue("add_ovf_sat", 32'h7FFF_FFFF, 32'h1, 0, 1, SatAddExp, 0, 1, 0);
    issue("sub_ovf_sat", 32'h8000_0000, 32'h1, 1, 1, SatSubExp, 1, 1, 0);
    drain("drain_directed");

    // Back-to-back stream with a 3-cycle output stall.
    fork
      begin
        for (int i = 0; i < 8; i++)
          issue($sformatf("stream%0d", i), i, 32'h100, 0, 0, 32'h100 + i, 0, 0, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 0;
        hold = out_sum;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 1'b0);
          chk("stall_out_valid", out_valid, 1'b1);
          chk("stall_hold_sum", out_sum, hold);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    drain("drain_stream");

    // Asynchronous reset with two ops in flight.
    issue("rst_victim0", 32'd1, 32'd2, 0, 0, 32'd3, 0, 0, 0);
    issue("rst_victim1", 32'd3, 32'd4, 0, 0, 32'd7, 0, 0, 0);
    #1;
    rst_n = 0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_sum", out_sum, 32'h0);
    chk("async_rst_flags", {out_carry, out_ovf, out_zero}, 3'b000);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    issue("after_rst", 32'd10, 32'd20, 0, 0, 32'd30, 0, 0, 0);
    wait_out("latency_after_rst", 2);
    drain("drain_after_rst");

    // Flush while stalled, then one op must take the normal 2 cycles.
    out_ready = 0;
    issue("flush_victim0", 32'd5, 32'd6, 0, 0, 32'd11, 0, 0, 0);
    issue("flush_victim1", 32'd7, 32'd8, 0, 0, 32'd15, 0, 0, 0);
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    chk("flush_clears_valid", out_valid, 1'b0);
    exp_q.delete();
    out_ready = 1;
    issue("after_flush", 32'h1234_0000, 32'h0000_5678, 0, 0, 32'h1234_5678, 0, 0, 0);
    wait_out("latency_after_flush", 2);
    drain("drain_after_flush");

    // Flush with a fresh beat presented: both the in-flight op and the beat vanish.
    issue("flush_victim2", 32'd9, 32'd9, 0, 0, 32'd18, 0, 0, 0);
    flush = 1; in_valid = 1; in_a = 32'd100; in_b = 32'd1;
    @(posedge clk);
    #1;
    flush = 0; in_valid = 0;
    exp_q.delete();
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("flush_discard", n, 0);

    // WIDTH=64, STAGES=4 full carry ripple.
    v64 = 1; a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'h1;
    @(posedge clk);
    #1;
    v64 = 0;
    n = 1;
    while (!ov64 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w64_latency", n, 4);
    chk("w64_sum", s64, 64'h0);
    chk("w64_flags", {c64, o64, z64}, 3'b101);

    // WIDTH=32, STAGES=1 single registered adder.
    v1 = 1; a1 = 32'd3; b1 = 32'd4;
    @(posedge clk);
    #1;
    v1 = 0;
    chk("s1_valid_latency1", ov1, 1'b1);
    chk("s1_sum", s1, 32'd7);
    chk("s1_flags", {c1, o1, z1}, 3'b000);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
